rand_chk_uni: RTL and testbench

- Receive-side checker for the xorshift128 uniform random stream produced by the on-chip generator (generator output is the W register).
- Self-synchronises by loading four consecutive received words as its own X/Y/Z/W state.
- After lock, predicts every following word and counts mismatches.
- Sits on the loopback/ADC-return path; status and counters go to the register bank.

---
 rtl/rand_xs128_pkg.sv | 22 ++
 rtl/rand_chk_uni_if.sv | 13 +
 rtl/rand_xs128_step.sv | 9 +
 rtl/rand_chk_uni.sv | 82 ++++++++
 tb/tb_rand_chk_uni.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/rand_xs128_pkg.sv
// rand_xs128_pkg: xorshift128 seeds, checker state type and the shared step function.
package rand_xs128_pkg;
    localparam logic [31:0] SEED_X = 32'd123456789;
    localparam logic [31:0] SEED_Y = 32'd362436069;
    localparam logic [31:0] SEED_Z = 32'd521288629;
    localparam logic [31:0] SEED_W = 32'd88675123;

    typedef enum logic {HUNT, CHECK} state_t;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] w;
    } xs_state_t;

    function automatic logic [31:0] xs128_step(input xs_state_t s);
        logic [31:0] t;
        t = s.x ^ (s.x << 11);
        return s.w ^ (s.w >> 19) ^ t ^ (t >> 8);
    endfunction
endpackage

// File: rtl/rand_chk_uni_if.sv
// rand_chk_uni_if: received-word strobe plus checker status toward the register bank.
interface rand_chk_uni_if #(parameter int CNT_W = 32);
    logic [31:0]      din;
    logic             din_valid;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] word_cnt;
    logic [31:0]      expected;

    modport master (output din, din_valid, input locked, err_pulse, err_cnt, word_cnt, expected);
    modport slave (input din, din_valid, output locked, err_pulse, err_cnt, word_cnt, expected);
endinterface

// File: rtl/rand_xs128_step.sv
// rand_xs128_step: combinational xorshift128 next-W, shareable with the generator.
module rand_xs128_step
    import rand_xs128_pkg::*;
(
    input  xs_state_t   i_s,
    output logic [31:0] o_w
);
    assign o_w = xs128_step(i_s);
endmodule

// File: rtl/rand_chk_uni.sv
// rand_chk_uni: self-synchronising xorshift128 stream checker.
// Define RAND_CHK_LOSS_EN to drop lock after LOSS_THR consecutive mismatches and re-hunt.
module rand_chk_uni
    import rand_xs128_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int LOSS_THR = 4
) (
    input logic            clk,
    input logic            rst,
    rand_chk_uni_if.slave  bus
);
    if (LOSS_THR < 1 || LOSS_THR > 15) begin : g_thr_range
        $error("LOSS_THR must be in 1..15");
    end

    state_t           r_state;
    logic [1:0]       r_fill;
    xs_state_t        r_s;
    logic [31:0]      r_exp;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_word_cnt;
    xs_state_t        w_nx;
    logic [31:0]      w_step;
    logic             w_mis;
    logic             w_loss;

    // While locked the state advances with the prediction, so a corrupt word never poisons it.
    assign w_nx  = {r_s.y, r_s.z, r_s.w, (r_state == HUNT) ? bus.din : r_exp};
    assign w_mis = (r_state == CHECK) && (bus.din != r_exp);

    rand_xs128_step u_step (.i_s(w_nx), .o_w(w_step));

`ifdef RAND_CHK_LOSS_EN
    logic [3:0] r_cerr;
    assign w_loss = w_mis && (r_cerr == 4'(LOSS_THR - 1));
    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_cerr <= '0;
        else if (bus.din_valid && r_state == CHECK)
            r_cerr <= (w_mis && !w_loss) ? r_cerr + 4'd1 : 4'd0;
`else
    assign w_loss = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state    <= HUNT;
            r_fill     <= '0;
            r_s        <= '0;
            r_exp      <= '0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
            r_word_cnt <= '0;
        end else begin
            r_err <= bus.din_valid && w_mis;
            if (bus.din_valid) begin
                r_s   <= w_nx;
                r_exp <= w_step;
                if (r_state == HUNT) begin
                    r_fill <= r_fill + 2'd1;
                    if (r_fill == 2'd3)
                        r_state <= CHECK;
                end else begin
                    r_word_cnt <= r_word_cnt + CNT_W'(r_word_cnt != '1);
                    if (w_mis)
                        r_err_cnt <= r_err_cnt + CNT_W'(r_err_cnt != '1);
                    if (w_loss) begin
                        r_state <= HUNT;
                        r_fill  <= '0;
                    end
                end
            end
        end

    assign bus.locked    = r_state == CHECK;
    assign bus.err_pulse = r_err;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.word_cnt  = r_word_cnt;
    assign bus.expected  = r_exp;
endmodule

// File: tb/tb_rand_chk_uni.sv
// tb_rand_chk_uni: directed streams into rand_chk_uni with a queue scoreboard and negedge monitor.
module tb_rand_chk_uni;
    import rand_xs128_pkg::*;

    localparam int LOSS_THR = 4;

    typedef struct {
        bit          lock;
        bit          err;
        logic [31:0] exp;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    item_t q[$];
    bit v_d = 1'b0;

    bit        t_lock;
    int        t_fill;
    int        t_cerr;
    xs_state_t ps;
    xs_state_t gs;

    logic [31:0] seq6 [6] = '{32'd88675123, 32'd3701687786, 32'd458299110,
                              32'd2500872618, 32'd3633119408, 32'd516391518};

    rand_chk_uni_if #(.CNT_W(32)) ifc ();
    rand_chk_uni_if #(.CNT_W(3))  ifs ();

    assign ifs.din       = ifc.din;
    assign ifs.din_valid = ifc.din_valid;

    rand_chk_uni #(.CNT_W(32), .LOSS_THR(LOSS_THR)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));
    rand_chk_uni #(.CNT_W(3),  .LOSS_THR(LOSS_THR)) dut_s (.clk(clk), .rst(rst), .bus(ifs.slave));

    always #5 clk = ~clk;

    function automatic logic [31:0] m_step(input xs_state_t s);
        logic [31:0] t;
        t = s.x ^ (s.x << 11);
        return s.w ^ (s.w >> 19) ^ t ^ (t >> 8);
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", n, a, e);
        end
    endtask

    always @(posedge clk) v_d = rst ? 1'b0 : ifc.din_valid;

    always @(negedge clk) begin
        item_t it;
        if (!rst) begin
            if (v_d) begin
                if (q.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    it = q.pop_front();
                    chk("err_pulse", ifc.err_pulse, it.err);
                    chk("locked", ifc.locked, it.lock);
                    if (it.lock)
                        chk("expected", ifc.expected, it.exp);
                end
            end else begin
                chk("err_pulse_idle", ifc.err_pulse, 0);
            end
        end
    end

    task automatic mdl_reset();
        t_lock = 1'b0;
        t_fill = 0;
        t_cerr = 0;
        ps     = '0;
        gs     = {SEED_X, SEED_Y, SEED_Z, SEED_W};
    endtask

    task automatic gen_word(output logic [31:0] w);
        w  = gs.w;
        gs = {gs.y, gs.z, gs.w, m_step(gs)};
    endtask

    task automatic send(input logic [31:0] d);
        item_t       it;
        logic [31:0] p;
        ifc.din       = d;
        ifc.din_valid = 1'b1;
        it.err = 1'b0;
        if (!t_lock) begin
            ps = {ps.y, ps.z, ps.w, d};
            t_fill++;
            if (t_fill == 4) begin
                t_lock = 1'b1;
                t_fill = 0;
            end
        end else begin
            p      = m_step(ps);
            it.err = (d != p);
            ps     = {ps.y, ps.z, ps.w, p};
`ifdef RAND_CHK_LOSS_EN
            t_cerr = it.err ? t_cerr + 1 : 0;
            if (t_cerr == LOSS_THR) begin
                t_lock = 1'b0;
                t_fill = 0;
                t_cerr = 0;
            end
`endif
        end
        it.lock = t_lock;
        it.exp  = m_step(ps);
        q.push_back(it);
        @(posedge clk);
        #1;
        ifc.din_valid = 1'b0;
        ifc.din       = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            ifc.din = $urandom;
        end
    endtask

    // Reset lands between clock edges; outputs must clear with no edge in between.
    task automatic rst_async(input string tag);
        idle(2);
        #2;
        rst = 1'b1;
        #1;
        chk({tag, "_locked"}, ifc.locked, 0);
        chk({tag, "_err_pulse"}, ifc.err_pulse, 0);
        chk({tag, "_err_cnt"}, ifc.err_cnt, 0);
        chk({tag, "_word_cnt"}, ifc.word_cnt, 0);
        chk({tag, "_expected"}, ifc.expected, 0);
        #3;
        rst = 1'b0;
        mdl_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        ifc.din       = '0;
        ifc.din_valid = 1'b0;
        mdl_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_locked", ifc.locked, 0);
        chk("reset_err_pulse", ifc.err_pulse, 0);
        chk("reset_err_cnt", ifc.err_cnt, 0);
        chk("reset_word_cnt", ifc.word_cnt, 0);
        chk("reset_expected", ifc.expected, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) gen_word(w);
        for (int i = 0; i < 1000; i++) begin
            if (i < 6) w = seq6[i];
            else gen_word(w);
            send(w);
            if (i == 3) begin
                chk("lock_after_4", ifc.locked, 1);
                chk("first_expected", ifc.expected, 32'd3633119408);
            end
        end
        idle(2);
        chk("clean_err_cnt", ifc.err_cnt, 0);
        chk("clean_word_cnt", ifc.word_cnt, 996);
        chk("sat_word_cnt", ifs.word_cnt, 7);
        chk("sat_err_cnt_clean", ifs.err_cnt, 0);
        rst_async("async_rst");

        for (int i = 0; i < 6; i++) gen_word(w);
        for (int i = 0; i < 20; i++) begin
            if (i < 6) w = seq6[i] ^ ((i == 5) ? 32'h1 : 32'h0);
            else gen_word(w);
            send(w);
        end
        idle(2);
        chk("corrupt_err_cnt", ifc.err_cnt, 1);
        chk("corrupt_word_cnt", ifc.word_cnt, 16);
        chk("corrupt_locked", ifc.locked, 1);
        rst_async("rst2");

        for (int i = 0; i < 30; i++) begin
            gen_word(w);
            send(w);
            idle(2);
        end
        chk("sparse_err_cnt", ifc.err_cnt, 0);
        chk("sparse_word_cnt", ifc.word_cnt, 26);
        rst_async("rst3");

        for (int i = 0; i < 4; i++) begin
            gen_word(w);
            send(w);
        end
        for (int i = 0; i < 12; i++) begin
            send(32'h0);
`ifdef RAND_CHK_LOSS_EN
            if (i == 3) chk("loss_locked_drop", ifc.locked, 0);
            if (i == 7) chk("relock", ifc.locked, 1);
`else
            if (i == 3) chk("no_loss_locked", ifc.locked, 1);
`endif
        end
        idle(2);
`ifdef RAND_CHK_LOSS_EN
        chk("zero_err_cnt", ifc.err_cnt, 4);
        chk("zero_word_cnt", ifc.word_cnt, 8);
        chk("zero_expected", ifc.expected, 0);
        chk("zero_sat_err_cnt", ifs.err_cnt, 4);
`else
        chk("zero_err_cnt", ifc.err_cnt, 12);
        chk("zero_word_cnt", ifc.word_cnt, 12);
        chk("zero_sat_err_cnt", ifs.err_cnt, 7);
`endif
        chk("zero_locked", ifc.locked, 1);
        chk("zero_sat_word_cnt", ifs.word_cnt, 7);
        chk("scoreboard_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
